alu_operand_stage: RTL and testbench

- Operand-fetch / write-back stage wrapped around the combinational ALU; owns the 16x32 general register file and the flag register.
- Accepts one decoded instruction per handshake, reads operands, drives ALU inputs, captures ALU result and flags, writes back to the register file.
- Serialised, non-pipelined: exactly one instruction in flight; upstream decode feeds it, ALU sits beside it.

---
 rtl/alu_operand_stage.sv | 139 +++++++++++++
 tb/tb_alu_operand_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Operand-fetch / write-back stage beside a combinational ALU. It owns the 16x32 register file and the flags.
// Only one instruction is in flight at a time: IDLE -> READ -> EXEC -> WB.
module alu_operand_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       imm,
  input  logic              use_imm,
  input  logic [4:0]        shamt_in,
  input  logic [3:0]        alu_ctrl_in,
  input  logic              wr_en_in,
  output logic [DATA_W-1:0] alu_inp1,
  output logic [DATA_W-1:0] alu_inp2,
  output logic [4:0]        alu_shamt,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic              alu_neg,
  input  logic              alu_zero,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_carry,
  output logic              flag_neg,
  output logic              flag_zero,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic [ADDR_W-1:0]        rs_p0, rt_p0, rd_p0;
  logic signed [15:0]       imm_p0;
  logic                     use_imm_p0, wr_en_p0;
  logic [4:0]               shamt_p0;
  logic [3:0]               ctrl_p0;
  logic signed [DATA_W-1:0] op1_p1, op2_p1;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = issue_valid ? S_READ : S_IDLE;
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    issue_ready = (state == S_IDLE);
    done        = (state == S_WB);
  end

  // p0: instruction fields latched at the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_p0      <= '0;
      rt_p0      <= '0;
      rd_p0      <= '0;
      imm_p0     <= '0;
      use_imm_p0 <= 1'b0;
      shamt_p0   <= '0;
      ctrl_p0    <= '0;
      wr_en_p0   <= 1'b0;
    end else if (state == S_IDLE && issue_valid) begin
      rs_p0      <= rs_addr;
      rt_p0      <= rt_addr;
      rd_p0      <= rd_addr;
      imm_p0     <= imm;
      use_imm_p0 <= use_imm;
      shamt_p0   <= shamt_in;
      ctrl_p0    <= alu_ctrl_in;
      wr_en_p0   <= wr_en_in;
    end
  end

  // p1: operands read from the register file during READ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_p1 <= '0;
      op2_p1 <= '0;
    end else if (state == S_READ) begin
      op1_p1 <= regs[rs_p0];
      op2_p1 <= use_imm_p0 ? sext_imm(imm_p0) : regs[rt_p0];
    end
  end

  assign alu_inp1  = op1_p1;
  assign alu_inp2  = op2_p1;
  assign alu_shamt = shamt_p0;
  assign alu_ctrl  = ctrl_p0;

  // p2: ALU result and flags captured at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      flag_carry <= 1'b0;
      flag_neg   <= 1'b0;
      flag_zero  <= 1'b0;
    end else if (state == S_EXEC) begin
      result     <= alu_out;
      flag_carry <= alu_carry;
      flag_neg   <= alu_neg;
      flag_zero  <= alu_zero;
    end
  end

  // Write-back lands on the edge that leaves WB, so the next READ always sees it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == S_WB && wr_en_p0) begin
      regs[rd_p0] <= result;
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: a behavioural ALU sits beside the DUT.
// A register-array model predicts each instruction; a monitor checks every done pulse.
`timescale 1ns/100ps
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready;
  logic [3:0]  rs_addr, rt_addr, rd_addr, dbg_addr;
  logic [15:0] imm;
  logic        use_imm, wr_en_in;
  logic [4:0]  shamt_in, alu_shamt;
  logic [3:0]  alu_ctrl_in, alu_ctrl;
  logic [31:0] alu_inp1, alu_inp2, alu_out, result, dbg_data;
  logic        alu_carry, alu_neg, alu_zero, done;
  logic        flag_carry, flag_neg, flag_zero;

  always #10 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .imm(imm),
    .use_imm(use_imm), .shamt_in(shamt_in), .alu_ctrl_in(alu_ctrl_in), .wr_en_in(wr_en_in),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_neg(alu_neg), .alu_zero(alu_zero),
    .done(done), .result(result), .flag_carry(flag_carry), .flag_neg(flag_neg),
    .flag_zero(flag_zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Environment ALU: bit 32 is carry (add) or borrow (sub)
  function automatic logic [32:0] alu_f(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] t;
    case (c)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return {1'b0, a << sh};
      4'd6:    return {1'b0, a >> sh};
      4'd7:    begin t = $signed(a) >>> sh; return {1'b0, t}; end
      default: return {1'b0, b};
    endcase
  endfunction

  logic [32:0] alu_w;
  assign alu_w     = alu_f(alu_ctrl, alu_inp1, alu_inp2, alu_shamt);
  assign alu_out   = alu_w[31:0];
  assign alu_carry = alu_w[32];
  assign alu_neg   = alu_w[31];
  assign alu_zero  = (alu_w[31:0] == 32'd0);

  typedef struct {
    logic [31:0] op1, op2, res, rdval;
    logic [4:0]  sh;
    logic [3:0]  ctl, rd;
    logic        c, n, z;
    int          acc, gap;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mreg [16];
  int          cyc = 0;
  int          tests = 0, fails = 0;
  int          req = 0, ack = 0, req_kind = 0;
  bit          dbg_pend = 0;
  logic [3:0]  pend_rd;
  logic [31:0] pend_val;
  int          last_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: the only process that compares anything or drives dbg_addr
  initial begin
    exp_t e;
    dbg_addr = '0;
    forever begin
      @(negedge clk); #1;
      if (dbg_pend) begin
        dbg_addr = pend_rd; #0.4;
        chk("wb_visible", dbg_data, pend_val);
        dbg_pend = 0;
      end
      if (ack != req) begin
        if (req_kind == 1) begin
          chk("rst_ready", 32'(issue_ready), 32'd1);
          chk("rst_done", 32'(done), 32'd0);
          chk("rst_result", result, 32'd0);
          chk("rst_flags", {29'd0, flag_carry, flag_neg, flag_zero}, 32'd0);
          chk("rst_alu_in", alu_inp1 | alu_inp2 | 32'(alu_shamt) | 32'(alu_ctrl), 32'd0);
        end else begin
          for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i); #0.4;
            chk($sformatf("sweep_r%0d", i), dbg_data, mreg[i]);
          end
        end
        ack = req;
      end
      if (rst_n && done) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1, expected no pending instruction (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("flags_cnz", {29'd0, flag_carry, flag_neg, flag_zero}, {29'd0, e.c, e.n, e.z});
          chk("alu_inp1", alu_inp1, e.op1);
          chk("alu_inp2", alu_inp2, e.op2);
          chk("alu_shamt_ctrl", {23'd0, alu_shamt, alu_ctrl}, {23'd0, e.sh, e.ctl});
          chk("done_latency", 32'(cyc - e.acc), 32'd2);
          if (e.gap != 0) chk("issue_cadence", 32'(cyc - last_done), 32'(e.gap));
          last_done = cyc;
          dbg_pend  = 1;
          pend_rd   = e.rd;
          pend_val  = e.rdval;
        end
      end
    end
  end

  // Reference model: architectural effect of one instruction, evaluated at acceptance
  task automatic push_expect(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                             input logic [15:0] im, input logic ui, input logic [4:0] sh,
                             input logic [3:0] ctl, input logic wr, input int acc, input int gap);
    exp_t        e;
    logic [32:0] r;
    e.op1 = mreg[rs];
    e.op2 = ui ? {{16{im[15]}}, im} : mreg[rt];
    r     = alu_f(ctl, e.op1, e.op2, sh);
    e.res = r[31:0];
    e.c   = r[32];
    e.n   = r[31];
    e.z   = (r[31:0] == 32'd0);
    if (wr) mreg[rd] = r[31:0];
    e.rdval = mreg[rd];
    e.sh = sh; e.ctl = ctl; e.rd = rd; e.acc = acc; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic request(input int kind);
    int t = 0;
    req_kind = kind;
    req++;
    while (ack != req) begin
      @(negedge clk);
      if (++t > 10) begin
        $display("FAIL monitor_request: got no acknowledge, expected one within 10 cycles");
        $fatal(1);
      end
    end
  endtask

  task automatic issue(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                       input logic [15:0] im, input logic ui, input logic [4:0] sh,
                       input logic [3:0] ctl, input logic wr, input bit expect_it, input int gap);
    int t = 0;
    @(negedge clk);
    while (!issue_ready) begin
      if (++t > 50) begin
        $display("FAIL issue_wait: got issue_ready=0, expected 1 within 50 cycles");
        $fatal(1);
      end
      @(negedge clk);
    end
    rs_addr = rs; rt_addr = rt; rd_addr = rd; imm = im; use_imm = ui;
    shamt_in = sh; alu_ctrl_in = ctl; wr_en_in = wr; issue_valid = 1'b1;
    if (expect_it) push_expect(rs, rt, rd, im, ui, sh, ctl, wr, cyc + 1, gap);
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic rand_fields();
    rs_addr = 4'($urandom_range(0, 15)); rt_addr = 4'($urandom_range(0, 15));
    rd_addr = 4'($urandom_range(0, 15)); imm = 16'($urandom);
    use_imm = 1'($urandom); shamt_in = 5'($urandom);
    alu_ctrl_in = 4'($urandom_range(0, 9)); wr_en_in = 1'($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 || dbg_pend) begin
      @(negedge clk);
      if (++t > 100) begin
        $display("FAIL drain: got %0d outstanding instructions, expected 0", q.size());
        $fatal(1);
      end
    end
  endtask

  initial begin
    int n, t;
    for (int i = 0; i < 16; i++) mreg[i] = 32'd0;
    rst_n = 1'b0; issue_valid = 1'b0;
    rs_addr = '0; rt_addr = '0; rd_addr = '0; imm = '0; use_imm = 1'b0;
    shamt_in = '0; alu_ctrl_in = '0; wr_en_in = 1'b0;
    repeat (2) @(negedge clk);
    request(1);
    @(negedge clk); rst_n = 1'b1;
    request(2);

    issue(4'd0, 4'd0, 4'd1, 16'd5,    1'b1, 5'd0, 4'd0, 1'b1, 1'b1, 0);
    issue(4'd1, 4'd0, 4'd2, 16'hFFFF, 1'b1, 5'd0, 4'd0, 1'b1, 1'b1, 4);
    issue(4'd2, 4'd2, 4'd3, 16'd0,    1'b0, 5'd0, 4'd0, 1'b1, 1'b1, 4);
    issue(4'd2, 4'd2, 4'd2, 16'd0,    1'b0, 5'd0, 4'd4, 1'b0, 1'b1, 4);

    for (int k = 0; k < 30; k++) begin
      rand_fields();
      issue(rs_addr, rt_addr, rd_addr, imm, use_imm, shamt_in, alu_ctrl_in, wr_en_in, 1'b1, 4);
    end

    // issue_valid held high; fields scrambled while the stage is busy
    rand_fields();
    issue_valid = 1'b1;
    n = 0; t = 0;
    while (n < 6) begin
      @(negedge clk);
      if (++t > 100) begin
        $display("FAIL hold_accept: got %0d accepts, expected 6 within 100 cycles", n);
        $fatal(1);
      end
      if (issue_ready) begin
        push_expect(rs_addr, rt_addr, rd_addr, imm, use_imm, shamt_in, alu_ctrl_in, wr_en_in, cyc + 1, 4);
        n++;
      end else begin
        rand_fields();
      end
    end
    @(negedge clk);
    issue_valid = 1'b0;
    drain();
    request(2);

    // Reset during EXEC of a write to R5
    issue(4'd0, 4'd0, 4'd5, 16'h1234, 1'b1, 5'd0, 4'd0, 1'b1, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) mreg[i] = 32'd0;
    request(1);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    request(2);

    issue(4'd0, 4'd0, 4'd6, 16'h8000, 1'b1, 5'd0, 4'd0, 1'b1, 1'b1, 0);
    drain();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
